exec_commit: RTL and testbench

- Commit stage directly downstream of the ALU. It accepts one ALU result beat per cycle over a valid/ready handshake.
- It holds the processor status register (PSR: C,L,F,N,Z) and feeds PSR.C back to the ALU CarryIn.
- It evaluates branch conditions against the PSR.
- It buffers register-file writebacks in a 2-entry FIFO, so a busy register-file write port back-pressures the ALU instead of dropping results.

---
 rtl/exec_commit.sv | 119 +++++++++++
 tb/tb_exec_commit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_commit.sv
// Commit stage: PSR, branch resolve, 2-entry writeback FIFO; wb_* valid one cycle after accept.
// Back-pressure: in_ready drops when the FIFO is full, derived from registered count only.
module exec_commit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_carry,
  input  logic                  in_low,
  input  logic                  in_flag,
  input  logic                  in_negative,
  input  logic                  in_zero,
  input  logic                  in_set_flags,
  input  logic                  in_wr_en,
  input  logic [ADDR_WIDTH-1:0] in_dest,
  input  logic                  in_is_branch,
  input  logic [3:0]            in_cond,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [4:0]            psr,
  output logic                  carry_out,
  output logic                  branch_taken,
  output logic                  branch_valid
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  wb_entry_t  mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;

  logic accept;
  logic push;
  logic pop;

  assign in_ready  = (count != 2'd2) & ~reset;
  assign accept    = in_valid & in_ready;
  assign push      = accept & in_wr_en;
  assign wb_valid  = (count != 2'd0);
  assign pop       = wb_valid & wb_ready;
  assign wb_addr   = mem[rd_ptr].addr;
  assign wb_data   = mem[rd_ptr].data;
  assign carry_out = psr[4];

  // psr layout is {C,L,F,N,Z}
  function automatic logic cond_met(input logic [3:0] cc, input logic [4:0] f);
    logic c, l, fl, n, z;
    logic r;
    c  = f[4];
    l  = f[3];
    fl = f[2];
    n  = f[1];
    z  = f[0];
    case (cc)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = l;
      4'b0101: r = ~l;
      4'b0110: r = n;
      4'b0111: r = ~n;
      4'b1000: r = fl;
      4'b1001: r = ~fl;
      4'b1010: r = ~l & ~z;
      4'b1011: r = l | z;
      4'b1100: r = ~n & ~z;
      4'b1101: r = n | z;
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0]       <= '0;
      mem[1]       <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      psr          <= 5'd0;
      branch_taken <= 1'b0;
      branch_valid <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{addr: in_dest, data: in_result};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      if (accept && in_set_flags) begin
        psr <= {in_carry, in_low, in_flag, in_negative, in_zero};
      end

      // Branch sees the PSR from before this beat's own flag update.
      branch_valid <= accept & in_is_branch;
      branch_taken <= accept & in_is_branch & cond_met(in_cond, psr);
    end
  end

endmodule

// File: tb/tb_exec_commit.sv
// Randomized bench for exec_commit against a queue-based model, plus directed literal checks.
module tb_exec_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic        in_carry, in_low, in_flag, in_negative, in_zero;
  logic        in_set_flags, in_wr_en, in_is_branch;
  logic [3:0]  in_dest;
  logic [3:0]  in_cond;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [4:0]  psr;
  logic        carry_out;
  logic        branch_taken;
  logic        branch_valid;

  exec_commit #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_carry(in_carry), .in_low(in_low), .in_flag(in_flag),
    .in_negative(in_negative), .in_zero(in_zero),
    .in_set_flags(in_set_flags), .in_wr_en(in_wr_en), .in_dest(in_dest),
    .in_is_branch(in_is_branch), .in_cond(in_cond),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .psr(psr), .carry_out(carry_out),
    .branch_taken(branch_taken), .branch_valid(branch_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } ent_t;

  ent_t       q[$];
  logic [4:0] m_psr;
  logic       m_bv, m_bt;
  logic       m_fresh;   // storage still holds reset zeros
  logic       m_live = 1'b0;

  // Conditions come in complementary pairs: odd code = negation of the even one.
  function automatic logic cond_ref(input logic [3:0] cc, input logic [4:0] p);
    logic c, l, f, n, z, base;
    {c, l, f, n, z} = p;
    case (cc >> 1)
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = l;
      3'd3: base = n;
      3'd4: base = f;
      3'd5: base = !l && !z;
      3'd6: base = !n && !z;
      default: base = 1'b1;
    endcase
    return base ^ cc[0];
  endfunction

  always @(posedge clk) begin
    bit acc, do_pop, do_push;
    if (reset) begin
      q.delete();
      m_psr   = 5'd0;
      m_bv    = 1'b0;
      m_bt    = 1'b0;
      m_fresh = 1'b1;
      m_live  = 1'b1;
    end else if (m_live) begin
      acc     = in_valid && (q.size() != 2);
      do_pop  = (q.size() != 0) && wb_ready;
      do_push = acc && in_wr_en;
      m_bv    = acc && in_is_branch;
      m_bt    = m_bv && cond_ref(in_cond, m_psr);
      if (acc && in_set_flags)
        m_psr = {in_carry, in_low, in_flag, in_negative, in_zero};
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{a: in_dest, d: in_result});
        m_fresh = 1'b0;
      end
    end
  end

  // Single compare process
  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", in_ready, !reset && (q.size() != 2));
      chk("wb_valid", wb_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("wb_addr", wb_addr, q[0].a);
        chk("wb_data", wb_data, q[0].d);
      end else if (m_fresh) begin
        chk("wb_addr_rst", wb_addr, 0);
        chk("wb_data_rst", wb_data, 0);
      end
      chk("psr", psr, m_psr);
      chk("carry_out", carry_out, m_psr[4]);
      chk("branch_valid", branch_valid, m_bv);
      chk("branch_taken", branch_taken, m_bt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    in_valid = 0; in_result = '0; in_carry = 0; in_low = 0; in_flag = 0;
    in_negative = 0; in_zero = 0; in_set_flags = 0; in_wr_en = 0;
    in_dest = '0; in_is_branch = 0; in_cond = '0;
  endtask

  task automatic wr_beat(input logic [3:0] a, input logic [15:0] d);
    clr();
    in_valid = 1; in_wr_en = 1; in_dest = a; in_result = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    clr();
    reset = 1; wb_ready = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // reset then idle
    @(negedge clk);
    chk("L_idle_ready", in_ready, 1);
    chk("L_idle_wbv", wb_valid, 0);
    chk("L_idle_psr", psr, 0);
    chk("L_idle_cout", carry_out, 0);

    // single write
    step(); wr_beat(4'd3, 16'h1234);
    step(); clr();
    @(negedge clk);
    chk("L_sw_wbv", wb_valid, 1);
    chk("L_sw_addr", wb_addr, 3);
    chk("L_sw_data", wb_data, 16'h1234);
    @(negedge clk);
    chk("L_sw_drained", wb_valid, 0);

    // back-pressure
    step(); wb_ready = 0; wr_beat(4'd1, 16'h0001);
    step(); wr_beat(4'd2, 16'h0002);
    step(); wr_beat(4'd4, 16'h0003);
    @(negedge clk);
    chk("L_bp_full", in_ready, 0);
    chk("L_bp_head", wb_addr, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("L_bp_hold", wb_data, 16'h0001);
    chk("L_bp_still_full", in_ready, 0);
    step(); wb_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("L_bp_r2_addr", wb_addr, 2);
    chk("L_bp_slot", in_ready, 1);
    step(); clr();
    @(negedge clk);
    chk("L_bp_r3_data", wb_data, 16'h0003);
    chk("L_bp_r3_addr", wb_addr, 4);
    @(negedge clk);
    chk("L_bp_empty", wb_valid, 0);

    // flags
    step(); clr(); in_valid = 1; in_set_flags = 1; in_carry = 1; in_zero = 1;
    step(); clr(); in_valid = 1;
    @(negedge clk);
    chk("L_flags_psr", psr, 5'b10001);
    chk("L_flags_cout", carry_out, 1);
    step(); clr();
    @(negedge clk);
    chk("L_flags_hold", psr, 5'b10001);

    // branch uses old PSR
    step(); clr(); in_valid = 1; in_set_flags = 1; in_carry = 1; in_zero = 0;
    in_is_branch = 1; in_cond = 4'b0000;
    step(); clr(); in_valid = 1; in_is_branch = 1; in_cond = 4'b0000;
    @(negedge clk);
    chk("L_br_valid", branch_valid, 1);
    chk("L_br_taken_old", branch_taken, 1);
    chk("L_br_psr", psr, 5'b10000);
    step(); clr();
    @(negedge clk);
    chk("L_br2_valid", branch_valid, 1);
    chk("L_br2_taken", branch_taken, 0);
    @(negedge clk);
    chk("L_br_pulse", branch_valid, 0);

    // reset mid-operation
    step(); wb_ready = 0; wr_beat(4'd5, 16'hAAAA); in_set_flags = 1; in_flag = 1;
    step(); wr_beat(4'd6, 16'hBBBB);
    step(); clr(); reset = 1;
    @(negedge clk);
    chk("L_rst_full", wb_valid, 1);
    chk("L_rst_ready", in_ready, 0);
    step(); reset = 0; wb_ready = 1;
    @(negedge clk);
    chk("L_rst_wbv", wb_valid, 0);
    chk("L_rst_psr", psr, 0);
    chk("L_rst_data", wb_data, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("L_rst_no_stale", wb_valid, 0);

    // randomized phase, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      step();
      r = $urandom;
      in_valid     = r[0] | r[1];
      in_wr_en     = r[2] | r[3];
      in_set_flags = r[4];
      in_is_branch = r[5] & r[6];
      in_cond      = r[10:7];
      {in_carry, in_low, in_flag, in_negative, in_zero} = r[15:11];
      in_dest      = r[19:16];
      wb_ready     = (r[22:20] > 3'd2);
      reset        = (r[31:25] == 7'd0);
      r = $urandom;
      in_result    = r[15:0];
    end
    step(); clr(); reset = 0; wb_ready = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
